mem_port: RTL and testbench

Parametrised external memory port for the GB80 CPU. It replaces the single-entry bus buffer with a DEPTH-entry request queue, a valid/ready handshake on the core side and a programmable wait-state sequencer on the external side. The decode logic posts reads and writes without stalling, and the external bus sees one access at a time in strict request order. Read data returns on a one-cycle response strobe.

---
 rtl/mem_port_if.sv | 25 ++
 rtl/mem_port.sv | 154 +++++++++++++++
 tb/tb_mem_port.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_if.sv
// Core-side request/response bundle for mem_port: master is the CPU decode logic, slave is the port.
interface mem_port_if #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 8
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_we;
  logic                  req_hipage;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic                  rsp_valid;
  logic [DATA_WIDTH-1:0] rsp_rdata;
  logic                  busy;

  modport master (
    output req_valid, req_we, req_hipage, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, busy
  );

  modport slave (
    input  req_valid, req_we, req_hipage, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, busy
  );
endinterface

// File: rtl/mem_port.sv
// DEPTH-entry request queue feeding a strictly ordered external bus sequencer; read latency 3+WAIT_STATES,
// req_ready drops when the queue is full. MEM_PORT_HIPAGE_EN maps hipage requests onto the all-ones page.
module mem_port #(
  parameter int ADDR_WIDTH  = 16,
  parameter int DATA_WIDTH  = 8,
  parameter int DEPTH       = 4,
  parameter int WAIT_STATES = 0
) (
  input  logic                  clock,
  input  logic                  reset,
  mem_port_if.slave             core,
  output logic [ADDR_WIDTH-1:0] addr_ext,
  inout  wire  [DATA_WIDTH-1:0] data_ext,
  output logic                  mem_we,
  output logic                  mem_re
);
  localparam int PW = $clog2(DEPTH);
  localparam logic [PW-1:0] PTR_ONE = 1;
  localparam logic [PW:0]   CNT_ONE = 1;
  localparam logic [PW:0]   CNT_FULL = DEPTH[PW:0];

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RESP} state_t;

  logic [PW:0]           r_count;
  logic [PW-1:0]         r_wr_ptr;
  logic [PW-1:0]         r_rd_ptr;
  logic                  r_fifo_we    [DEPTH];
  logic [ADDR_WIDTH-1:0] r_fifo_addr  [DEPTH];
  logic [DATA_WIDTH-1:0] r_fifo_wdata [DEPTH];
  logic                  r_out_of_rst;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [3:0]            r_wcnt;
  logic                  r_acc_we;
  logic [DATA_WIDTH-1:0] r_acc_wdata;
  logic [ADDR_WIDTH-1:0] r_addr_ext;
  logic                  r_mem_we;
  logic                  r_mem_re;
  logic                  r_rsp_vld;
  logic [DATA_WIDTH-1:0] r_rsp_rdata;

  logic                  w_full;
  logic                  w_empty;
  logic                  w_push;
  logic                  w_pop;
  logic [ADDR_WIDTH-1:0] w_push_addr;
  logic                  w_acc_we_nxt;
  logic                  w_mem_we_d;
  logic                  w_mem_re_d;
  logic                  w_rsp_vld_d;
  logic                  w_capture;
  logic                  w_dext_oe;

  assign w_full         = (r_count == CNT_FULL);
  assign w_empty        = (r_count == '0);
  assign core.req_ready = r_out_of_rst & ~w_full;
  assign w_push         = core.req_valid & core.req_ready;
  assign w_pop          = (r_state == S_IDLE) & ~w_empty;

`ifdef MEM_PORT_HIPAGE_EN
  assign w_push_addr = core.req_hipage ? {{(ADDR_WIDTH-8){1'b1}}, core.req_addr[7:0]} : core.req_addr;
`else
  logic w_unused_hipage;
  assign w_unused_hipage = core.req_hipage;
  assign w_push_addr     = core.req_addr;
`endif

  // Queue storage carries no reset; validity is tracked solely by r_count.
  always_ff @(posedge clock) begin
    if (w_push) begin
      r_fifo_we[r_wr_ptr]    <= core.req_we;
      r_fifo_addr[r_wr_ptr]  <= w_push_addr;
      r_fifo_wdata[r_wr_ptr] <= core.req_wdata;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_count      <= '0;
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_out_of_rst <= 1'b0;
    end else begin
      r_out_of_rst <= 1'b1;
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (!w_empty) w_state_nxt = S_ACCESS;
      S_ACCESS: if (r_wcnt == '0) w_state_nxt = r_acc_we ? S_IDLE : S_RESP;
      S_RESP:   w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  // Strobes are computed from the next state so the bus pins come straight off flops.
  always_comb begin
    w_acc_we_nxt = w_pop ? r_fifo_we[r_rd_ptr] : r_acc_we;
    w_mem_we_d   = (w_state_nxt == S_ACCESS) & w_acc_we_nxt;
    w_mem_re_d   = (w_state_nxt == S_ACCESS) & ~w_acc_we_nxt;
    w_rsp_vld_d  = (w_state_nxt == S_RESP);
    w_capture    = (r_state == S_ACCESS) & (r_wcnt == '0) & ~r_acc_we;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_wcnt      <= '0;
      r_acc_we    <= 1'b0;
      r_acc_wdata <= '0;
      r_addr_ext  <= '0;
      r_mem_we    <= 1'b0;
      r_mem_re    <= 1'b0;
      r_rsp_vld   <= 1'b0;
      r_rsp_rdata <= '0;
    end else begin
      r_mem_we  <= w_mem_we_d;
      r_mem_re  <= w_mem_re_d;
      r_rsp_vld <= w_rsp_vld_d;
      if (w_pop) begin
        r_acc_we    <= r_fifo_we[r_rd_ptr];
        r_acc_wdata <= r_fifo_wdata[r_rd_ptr];
        r_addr_ext  <= r_fifo_addr[r_rd_ptr];
        r_wcnt      <= 4'(WAIT_STATES);
      end else if ((r_state == S_ACCESS) && (r_wcnt != '0)) begin
        r_wcnt <= r_wcnt - 4'd1;
      end
      if (w_capture) r_rsp_rdata <= data_ext;
    end
  end

  assign w_dext_oe      = r_mem_we;
  assign data_ext       = w_dext_oe ? r_acc_wdata : {DATA_WIDTH{1'bz}};
  assign addr_ext       = r_addr_ext;
  assign mem_we         = r_mem_we;
  assign mem_re         = r_mem_re;
  assign core.rsp_valid = r_rsp_vld;
  assign core.rsp_rdata = r_rsp_rdata;
  assign core.busy      = ~w_empty | (r_state != S_IDLE);
endmodule

// File: tb/tb_mem_port.sv
// Directed bench for mem_port: u0 runs with WAIT_STATES=0, u2 with WAIT_STATES=2, sharing clock and reset.
module tb_mem_port;
  localparam int AW    = 16;
  localparam int DW    = 8;
  localparam int DEPTH = 4;

`ifdef MEM_PORT_HIPAGE_EN
  localparam logic [AW-1:0] HP_ADDR = 16'hFF44;
  localparam logic [DW-1:0] HP_DATA = 8'h3C;
`else
  localparam logic [AW-1:0] HP_ADDR = 16'h0044;
  localparam logic [DW-1:0] HP_DATA = 8'hC3;
`endif

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  mem_port_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) if0 ();
  mem_port_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) if2 ();

  logic [AW-1:0] addr0, addr2;
  wire  [DW-1:0] dext0, dext2;
  logic          we0, re0, we2, re2;

  mem_port #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH), .WAIT_STATES(0)) u0 (
    .clock(clock), .reset(reset), .core(if0),
    .addr_ext(addr0), .data_ext(dext0), .mem_we(we0), .mem_re(re0)
  );

  mem_port #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH), .WAIT_STATES(2)) u2 (
    .clock(clock), .reset(reset), .core(if2),
    .addr_ext(addr2), .data_ext(dext2), .mem_we(we2), .mem_re(re2)
  );

  // External memory for u0: written locations remembered, fixed pattern elsewhere.
  logic [DW-1:0] mem0 [logic [AW-1:0]];
  logic [DW-1:0] rd0;
  always @(*) begin
    rd0 = 8'hEE;
    if (addr0 == 16'h1234) rd0 = 8'h5A;
    if (addr0 == 16'hFF44) rd0 = 8'h3C;
    if (addr0 == 16'h0044) rd0 = 8'hC3;
    if (mem0.exists(addr0)) rd0 = mem0[addr0];
  end
  assign dext0 = re0 ? rd0 : 8'bz;
  always @(posedge clock) if (we0) mem0[addr0] = dext0;

  assign dext2 = re2 ? 8'h96 : 8'bz;

  // Records the first cycle of every u2 write access.
  logic [AW-1:0] log_addr [$];
  logic [DW-1:0] log_data [$];
  time           log_t    [$];
  logic          prev_we2 = 1'b0;
  always @(negedge clock) begin
    if (we2 && !prev_we2) begin
      log_addr.push_back(addr2);
      log_data.push_back(dext2);
      log_t.push_back($time);
    end
    prev_we2 = we2;
  end

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic mid();
    @(negedge clock);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int acc_at [6];
    int cnum;
    int tries;
    logic rdy;

    if0.req_valid = 1'b0; if0.req_we = 1'b0; if0.req_hipage = 1'b0; if0.req_addr = '0; if0.req_wdata = '0;
    if2.req_valid = 1'b0; if2.req_we = 1'b0; if2.req_hipage = 1'b0; if2.req_addr = '0; if2.req_wdata = '0;

    // Reset state
    repeat (3) cyc();
    mid();
    chk("rst_ready0", if0.req_ready, 0);
    chk("rst_rsp_vld0", if0.rsp_valid, 0);
    chk("rst_rdata0", if0.rsp_rdata, 0);
    chk("rst_busy0", if0.busy, 0);
    chk("rst_addr0", addr0, 0);
    chk("rst_we0", we0, 0);
    chk("rst_re0", re0, 0);
    chk("rst_oe0", u0.w_dext_oe, 0);
    chk("rst_ready2", if2.req_ready, 0);
    chk("rst_busy2", if2.busy, 0);
    reset = 1'b1;
    cyc(); mid();
    chk("rel_ready0", if0.req_ready, 1);
    chk("rel_ready2", if2.req_ready, 1);

    // Single read at 0x1234, no wait states
    cyc();
    if0.req_valid = 1'b1; if0.req_we = 1'b0; if0.req_addr = 16'h1234;
    cyc();
    if0.req_valid = 1'b0;
    mid();
    chk("rd_c1_re", re0, 0);
    chk("rd_c1_busy", if0.busy, 1);
    cyc(); mid();
    chk("rd_c2_re", re0, 1);
    chk("rd_c2_we", we0, 0);
    chk("rd_c2_addr", addr0, 16'h1234);
    chk("rd_c2_vld", if0.rsp_valid, 0);
    cyc(); mid();
    chk("rd_c3_re", re0, 0);
    chk("rd_c3_vld", if0.rsp_valid, 1);
    chk("rd_c3_data", if0.rsp_rdata, 8'h5A);
    cyc(); mid();
    chk("rd_c4_vld", if0.rsp_valid, 0);
    chk("rd_c4_busy", if0.busy, 0);
    chk("rd_c4_hold", if0.rsp_rdata, 8'h5A);
    chk("rd_c4_addr_hold", addr0, 16'h1234);

    // Write 0x77 to 0xC000 with two wait states
    cyc();
    if2.req_valid = 1'b1; if2.req_we = 1'b1; if2.req_addr = 16'hC000; if2.req_wdata = 8'h77;
    cyc();
    if2.req_valid = 1'b0;
    mid();
    chk("wr_c1_we", we2, 0);
    chk("wr_c1_z", u2.w_dext_oe, 0);
    for (int k = 2; k <= 4; k++) begin
      cyc(); mid();
      chk($sformatf("wr_c%0d_we", k), we2, 1);
      chk($sformatf("wr_c%0d_re", k), re2, 0);
      chk($sformatf("wr_c%0d_data", k), dext2, 8'h77);
      chk($sformatf("wr_c%0d_addr", k), addr2, 16'hC000);
      chk($sformatf("wr_c%0d_vld", k), if2.rsp_valid, 0);
    end
    cyc(); mid();
    chk("wr_c5_we", we2, 0);
    chk("wr_c5_z", u2.w_dext_oe, 0);
    chk("wr_c5_vld", if2.rsp_valid, 0);
    cyc(); mid();
    chk("wr_c6_vld", if2.rsp_valid, 0);
    chk("wr_c6_busy", if2.busy, 0);

    // DEPTH+2 back-to-back writes into u2: queue fills, last request held off until a pop
    log_addr.delete(); log_data.delete(); log_t.delete();
    cyc();
    cnum = 0;
    for (int i = 0; i < 6; i++) begin
      if2.req_valid = 1'b1; if2.req_we = 1'b1;
      if2.req_addr = 16'h0200 + 16'(i); if2.req_wdata = 8'hB0 + 8'(i);
      rdy = 1'b0; tries = 0;
      while (!rdy && tries < 20) begin
        mid();
        rdy = if2.req_ready;
        cyc();
        cnum++;
        tries++;
      end
      acc_at[i] = cnum - 1;
    end
    if2.req_valid = 1'b0;
    mid();
    chk("fill_full_again", if2.req_ready, 0);
    chk("fill_acc0", acc_at[0], 0);
    chk("fill_acc3", acc_at[3], 3);
    chk("fill_acc4", acc_at[4], 4);
    chk("fill_acc5_held", acc_at[5], 6);
    tries = 0;
    do begin cyc(); mid(); tries++; end while (if2.busy && tries < 200);
    chk("fill_drain", if2.busy, 0);
    chk("fill_count", log_addr.size(), 6);
    for (int i = 0; i < log_addr.size() && i < 6; i++) begin
      chk($sformatf("fill_addr%0d", i), log_addr[i], 16'h0200 + 16'(i));
      chk($sformatf("fill_data%0d", i), log_data[i], 8'hB0 + 8'(i));
      if (i > 0) chk($sformatf("fill_gap%0d", i), 32'(log_t[i] - log_t[i-1]), 40);
    end

    // Write 0x11 to 0x8000 then read it back through u0
    cyc();
    if0.req_valid = 1'b1; if0.req_we = 1'b1; if0.req_addr = 16'h8000; if0.req_wdata = 8'h11;
    cyc();
    if0.req_we = 1'b0;
    cyc();
    if0.req_valid = 1'b0;
    mid();
    chk("raw_c2_we", we0, 1);
    chk("raw_c2_re", re0, 0);
    chk("raw_c2_addr", addr0, 16'h8000);
    cyc(); mid();
    chk("raw_c3_idle", {we0, re0}, 2'b00);
    cyc(); mid();
    chk("raw_c4_re", re0, 1);
    chk("raw_c4_we", we0, 0);
    cyc(); mid();
    chk("raw_c5_vld", if0.rsp_valid, 1);
    chk("raw_c5_data", if0.rsp_rdata, 8'h11);

    // High-page read
    cyc();
    if0.req_valid = 1'b1; if0.req_we = 1'b0; if0.req_hipage = 1'b1; if0.req_addr = 16'h0044;
    cyc();
    if0.req_valid = 1'b0; if0.req_hipage = 1'b0;
    cyc(); mid();
    chk("hp_c2_re", re0, 1);
    chk("hp_c2_addr", addr0, HP_ADDR);
    cyc(); mid();
    chk("hp_c3_vld", if0.rsp_valid, 1);
    chk("hp_c3_data", if0.rsp_rdata, HP_DATA);

    // Reset while u2 is mid-read with three entries queued
    cyc();
    if2.req_valid = 1'b1; if2.req_we = 1'b0; if2.req_addr = 16'h0300;
    cyc(); if2.req_addr = 16'h0301;
    cyc(); if2.req_addr = 16'h0302;
    cyc(); if2.req_addr = 16'h0303;
    cyc(); if2.req_valid = 1'b0;
    mid();
    chk("mr_c4_re", re2, 1);
    chk("mr_c4_busy", if2.busy, 1);
    reset = 1'b0;
    cyc(); mid();
    chk("mr_rst_re", re2, 0);
    chk("mr_rst_we", we2, 0);
    chk("mr_rst_busy", if2.busy, 0);
    chk("mr_rst_ready", if2.req_ready, 0);
    chk("mr_rst_vld", if2.rsp_valid, 0);
    reset = 1'b1;
    cyc(); mid();
    chk("mr_rel_ready", if2.req_ready, 1);
    for (int k = 0; k < 10; k++) begin
      chk($sformatf("mr_quiet%0d", k), {if2.rsp_valid, re2, we2, if2.busy}, 4'b0000);
      cyc(); mid();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
